// File: rtl/memory_writeback.sv
// memory_writeback: Y86-64 M stage with M/W pipeline registers and byte-addressed data memory.
module memory_writeback #(
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  E_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] E_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  E_dstM,
  input  logic        M_bubble,
  input  logic        W_stall,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [3:0]  m_stat,
  output logic [63:0] m_valM,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);
  localparam int AW = $clog2(DMEM_BYTES);
  localparam logic [3:0] AOK = 4'h1, ADR = 4'h3, NOP = 4'h1, RNONE = 4'hF;
  logic [7:0]    mem [DMEM_BYTES];
  logic [63:0]   addr, rd;
  logic [AW-1:0] base;
  logic          ren, wen, dmem_error;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM} <= {AOK, NOP, 1'b0, 64'd0, 64'd0, RNONE, RNONE};
    end else if (M_bubble) begin
      {M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM} <= {AOK, NOP, 1'b0, 64'd0, 64'd0, RNONE, RNONE};
    end else begin
      {M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM} <= {e_stat, E_icode, e_cnd, e_valE, E_valA, e_dstE, E_dstM};
    end
  end
  always_comb begin
    ren = M_icode == 4'h5 || M_icode == 4'h9 || M_icode == 4'hB;
    wen = M_icode == 4'h4 || M_icode == 4'h8 || M_icode == 4'hA;
    addr = (wen || M_icode == 4'h5) ? M_valE : (M_icode == 4'h9 || M_icode == 4'hB) ? M_valA : 64'd0;
    dmem_error = (ren || wen) && addr > 64'(DMEM_BYTES - 8);
    m_stat = dmem_error ? ADR : M_stat;
    m_valM = (ren && !dmem_error) ? rd : 64'd0;
  end
  assign base = addr[AW-1:0];
  for (genvar i = 0; i < 8; i++) begin : g_rd
    assign rd[8*i +: 8] = mem[base + AW'(i)];
  end
  // While rst_n is low the M register is held at a nop, so wen already blocks writes.
  always_ff @(posedge clk) begin
    if (wen && !dmem_error)
      for (int i = 0; i < 8; i++) mem[base + AW'(i)] <= M_valA[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM} <= {AOK, NOP, 64'd0, 64'd0, RNONE, RNONE};
    end else if (!W_stall) begin
      {W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM} <= {m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM};
    end
  end
endmodule

// File: tb/tb_memory_writeback.sv
// tb_memory_writeback: directed checks of the M stage, data memory and M/W registers.
module tb_memory_writeback;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  e_stat, E_icode, e_dstE, E_dstM;
  logic        e_cnd, M_bubble, W_stall;
  logic [63:0] e_valE, E_valA;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM, m_stat, W_stat, W_icode, W_dstE, W_dstM;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA, m_valM, W_valE, W_valM;
  int n_tests = 0, n_fail = 0;

  memory_writeback #(.DMEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .e_stat(e_stat), .E_icode(E_icode), .e_cnd(e_cnd),
    .e_valE(e_valE), .E_valA(E_valA), .e_dstE(e_dstE), .E_dstM(E_dstM),
    .M_bubble(M_bubble), .W_stall(W_stall), .M_stat(M_stat), .M_icode(M_icode),
    .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_stat(m_stat), .m_valM(m_valM), .W_stat(W_stat), .W_icode(W_icode),
    .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM));

  always #5 clk = ~clk;

  task automatic load_e(input logic [3:0] icode, input logic [63:0] vale, input logic [63:0] vala,
                        input logic [3:0] dste, input logic [3:0] dstm);
    e_stat = 4'h1; E_icode = icode; e_cnd = 1'b1; e_valE = vale; E_valA = vala; e_dstE = dste; E_dstM = dstm;
  endtask

  task automatic nop_e();
    load_e(4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nop_e(); M_bubble = 0; W_stall = 0; rst_n = 0;
    tick(); tick();
    n_tests++; if (M_icode !== 4'h1) begin n_fail++; $display("FAIL reset_M_icode got %h exp 1", M_icode); end
    n_tests++; if (W_icode !== 4'h1) begin n_fail++; $display("FAIL reset_W_icode got %h exp 1", W_icode); end
    n_tests++; if (M_stat !== 4'h1 || W_stat !== 4'h1) begin n_fail++; $display("FAIL reset_stat got %h/%h exp 1/1", M_stat, W_stat); end
    n_tests++; if ({M_dstE, M_dstM, W_dstE, W_dstM} !== 16'hFFFF) begin n_fail++; $display("FAIL reset_dst got %h exp ffff", {M_dstE, M_dstM, W_dstE, W_dstM}); end
    n_tests++; if (m_valM !== 64'd0) begin n_fail++; $display("FAIL reset_m_valM got %h exp 0", m_valM); end
    rst_n = 1;
    tick();
    n_tests++; if (M_icode !== 4'h1 || W_icode !== 4'h1) begin n_fail++; $display("FAIL release_bubble got %h/%h exp 1/1", M_icode, W_icode); end
  endtask

  task automatic test_rmmov_mrmov();
    load_e(4'h4, 64'h40, 64'h0123456789ABCDEF, 4'hF, 4'hF);
    tick();
    n_tests++; if (M_icode !== 4'h4 || M_valE !== 64'h40) begin n_fail++; $display("FAIL rmmov_M got %h/%h exp 4/40", M_icode, M_valE); end
    load_e(4'h5, 64'h40, 64'd0, 4'hF, 4'h3);
    tick();
    n_tests++; if (m_valM !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL mrmov_m_valM got %h exp 0123456789abcdef", m_valM); end
    n_tests++; if (dut.mem[64] !== 8'hEF) begin n_fail++; $display("FAIL mem_byte40 got %h exp ef", dut.mem[64]); end
    n_tests++; if (W_icode !== 4'h4 || W_valE !== 64'h40) begin n_fail++; $display("FAIL rmmov_W got %h/%h exp 4/40", W_icode, W_valE); end
    nop_e();
    tick();
    n_tests++; if (W_valM !== 64'h0123456789ABCDEF || W_dstM !== 4'h3) begin n_fail++; $display("FAIL mrmov_W got %h/%h exp 0123456789abcdef/3", W_valM, W_dstM); end
  endtask

  task automatic test_push_pop();
    load_e(4'hA, 64'h1F8, 64'd7, 4'h4, 4'hF);
    tick();
    load_e(4'hB, 64'h200, 64'h1F8, 4'h4, 4'h2);
    tick();
    n_tests++; if (m_valM !== 64'd7) begin n_fail++; $display("FAIL pop_m_valM got %h exp 7", m_valM); end
    n_tests++; if (m_stat !== 4'h1) begin n_fail++; $display("FAIL pop_m_stat got %h exp 1", m_stat); end
    nop_e();
    tick();
  endtask

  task automatic test_adr();
    load_e(4'h4, 64'd1016, 64'h1122334455667788, 4'hF, 4'hF);
    tick();
    n_tests++; if (m_stat !== 4'h1) begin n_fail++; $display("FAIL edge_ok_stat got %h exp 1", m_stat); end
    load_e(4'h5, 64'd1020, 64'd0, 4'hF, 4'h3);
    tick();
    n_tests++; if (m_stat !== 4'h3 || m_valM !== 64'd0) begin n_fail++; $display("FAIL adr_read got %h/%h exp 3/0", m_stat, m_valM); end
    load_e(4'h4, 64'd1020, 64'hDEADBEEFDEADBEEF, 4'hF, 4'hF);
    tick();
    n_tests++; if (W_stat !== 4'h3) begin n_fail++; $display("FAIL adr_W_stat got %h exp 3", W_stat); end
    n_tests++; if (m_stat !== 4'h3) begin n_fail++; $display("FAIL adr_write_stat got %h exp 3", m_stat); end
    load_e(4'h5, 64'hFFFFFFFFFFFFFFF8, 64'd0, 4'hF, 4'h3);
    tick();
    n_tests++; if (m_stat !== 4'h3) begin n_fail++; $display("FAIL adr_nowrap got %h exp 3", m_stat); end
    load_e(4'h5, 64'd1016, 64'd0, 4'hF, 4'h3);
    tick();
    n_tests++; if (m_valM !== 64'h1122334455667788 || m_stat !== 4'h1) begin n_fail++; $display("FAIL adr_unchanged got %h/%h exp 1122334455667788/1", m_valM, m_stat); end
    nop_e();
    tick();
  endtask

  task automatic test_bubble_stall();
    load_e(4'h4, 64'h80, 64'hAAAA5555AAAA5555, 4'hF, 4'hF);
    tick();
    load_e(4'h4, 64'h80, 64'hBBBBBBBBBBBBBBBB, 4'hF, 4'hF);
    M_bubble = 1;
    tick();
    M_bubble = 0;
    n_tests++; if (M_icode !== 4'h1 || M_dstE !== 4'hF) begin n_fail++; $display("FAIL bubble_M got %h/%h exp 1/f", M_icode, M_dstE); end
    load_e(4'h5, 64'h80, 64'd0, 4'hF, 4'h5);
    tick();
    n_tests++; if (m_valM !== 64'hAAAA5555AAAA5555) begin n_fail++; $display("FAIL bubble_nowrite got %h exp aaaa5555aaaa5555", m_valM); end
    nop_e();
    tick();
    W_stall = 1;
    load_e(4'h3, 64'h55, 64'd0, 4'h2, 4'hF);
    tick();
    n_tests++; if (M_icode !== 4'h3 || W_icode !== 4'h5 || W_valM !== 64'hAAAA5555AAAA5555) begin n_fail++; $display("FAIL stall1 got %h/%h/%h exp 3/5/aaaa5555aaaa5555", M_icode, W_icode, W_valM); end
    load_e(4'h6, 64'h66, 64'd0, 4'h1, 4'hF);
    tick();
    n_tests++; if (M_valE !== 64'h66 || W_dstM !== 4'h5 || W_icode !== 4'h5) begin n_fail++; $display("FAIL stall2 got %h/%h/%h exp 66/5/5", M_valE, W_dstM, W_icode); end
    W_stall = 0;
    nop_e();
    tick();
    n_tests++; if (W_icode !== 4'h6 || W_valE !== 64'h66 || W_dstE !== 4'h1) begin n_fail++; $display("FAIL stall_release got %h/%h/%h exp 6/66/1", W_icode, W_valE, W_dstE); end
  endtask

  task automatic test_reset_mid();
    load_e(4'h4, 64'hC0, 64'h0000111122223333, 4'hF, 4'hF);
    tick();
    load_e(4'h4, 64'hC0, 64'h9999888877776666, 4'hF, 4'hF);
    tick();
    nop_e();
    #2 rst_n = 0;
    #1;
    n_tests++; if (M_icode !== 4'h1 || W_icode !== 4'h1 || W_dstE !== 4'hF) begin n_fail++; $display("FAIL midreset_async got %h/%h/%h exp 1/1/f", M_icode, W_icode, W_dstE); end
    tick();
    #2 rst_n = 1;
    load_e(4'h5, 64'hC0, 64'd0, 4'hF, 4'h3);
    tick();
    n_tests++; if (m_valM !== 64'h0000111122223333) begin n_fail++; $display("FAIL midreset_nowrite got %h exp 0000111122223333", m_valM); end
    nop_e();
    tick();
  endtask

  initial begin
    test_reset();
    test_rmmov_mrmov();
    test_push_pop();
    test_adr();
    test_bubble_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
